// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch and load/store ports, the arbiter and the unified memory bus.
// The master side is the core plus the memory; the slave side is the arbiter.
interface mem_port_arbiter_if;
   // instruction-fetch port
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_fault;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   // load/store port
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [2:0]  d_width;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_fault;
   logic        d_rvalid;
   logic [63:0] d_rdata;

   // unified memory bus
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_ack;
   logic [63:0] bus_rdata;

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_fault, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_width, d_wdata,
      input  d_gnt, d_fault, d_rvalid, d_rdata,
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
      output bus_ack, bus_rdata
   );

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_fault, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_width, d_wdata,
      output d_gnt, d_fault, d_rvalid, d_rdata,
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
      input  bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory bus, one access at a time, with
// data priority bounded by a fetch-starvation limit; also does byte-lane steering and load extension.
module mem_port_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  mp
);

   localparam logic [2:0] MAX_STREAK = 3'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  streak_q;

   logic        if_fault_c, d_fault_c;
   logic        if_gnt_c, d_gnt_c;
   logic        if_ok, d_ok;

   // access latched at grant
   logic        sel_d_p1;
   logic        req_we_p1;
   logic [2:0]  req_width_p1;
   logic [63:0] req_addr_p1;
   logic [63:0] req_wdata_p1;

   // results captured on bus_ack
   logic [31:0] if_rdata_p2;
   logic [63:0] d_rdata_p2;

   logic        busy;
   logic        busy_d;

   // Address is misaligned when it is not a multiple of the access size.
   function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size_code);
      logic bad;
      case (size_code)
         2'd0:    bad = 1'b0;
         2'd1:    bad = off[0];
         2'd2:    bad = |off[1:0];
         default: bad = |off;
      endcase
      return bad;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size_code);
      logic [7:0] m;
      case (size_code)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   // Shift the addressed lanes down, then sign- or zero-extend to 64 bits.
   function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] off,
                                               input logic [2:0] width);
      logic [63:0]        shifted;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      logic signed [63:0] ext;
      shifted = raw >> {off, 3'b000};
      b = shifted[7:0];
      h = shifted[15:0];
      w = shifted[31:0];
      case (width[1:0])
         2'd0:    ext = width[2] ? {56'd0, shifted[7:0]}  : 64'(b);
         2'd1:    ext = width[2] ? {48'd0, shifted[15:0]} : 64'(h);
         2'd2:    ext = width[2] ? {32'd0, shifted[31:0]} : 64'(w);
         default: ext = shifted;
      endcase
      return ext;
   endfunction

   function automatic logic d_illegal(input logic we, input logic [2:0] width, input logic [2:0] off);
      return (width == 3'b111) || (we && width[2]) || misaligned(off, width[1:0]);
   endfunction

   // Stage 0: combinational arbitration and fault detection in IDLE
   always_comb begin
      state_d    = state_q;
      if_fault_c = 1'b0;
      d_fault_c  = 1'b0;
      if_ok      = 1'b0;
      d_ok       = 1'b0;
      if_gnt_c   = 1'b0;
      d_gnt_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst) begin
               if_fault_c = mp.if_req && (mp.if_addr[1:0] != 2'b00);
               d_fault_c  = mp.d_req && d_illegal(mp.d_we, mp.d_width, mp.d_addr[2:0]);
               if_ok      = mp.if_req && !if_fault_c;
               d_ok       = mp.d_req && !d_fault_c;
               if (if_ok && d_ok) begin
                  if (streak_q == MAX_STREAK) if_gnt_c = 1'b1;
                  else                        d_gnt_c  = 1'b1;
               end else begin
                  if_gnt_c = if_ok;
                  d_gnt_c  = d_ok;
               end
               if (if_gnt_c)     state_d = BUSY_IF;
               else if (d_gnt_c) state_d = BUSY_D;
            end
         end
         BUSY_IF: if (mp.bus_ack) state_d = DONE;
         BUSY_D:  if (mp.bus_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         streak_q <= 3'd0;
         sel_d_p1 <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!mp.if_req || if_gnt_c)
            streak_q <= 3'd0;
         else if (d_gnt_c && (streak_q != 3'd7))
            streak_q <= streak_q + 3'd1;
         if (if_gnt_c)     sel_d_p1 <= 1'b0;
         else if (d_gnt_c) sel_d_p1 <= 1'b1;
      end
   end

   // Stage 1: latched access held on the bus until acknowledged
   always_ff @(posedge clk) begin
      if (if_gnt_c) begin
         req_addr_p1  <= mp.if_addr;
         req_we_p1    <= 1'b0;
         req_width_p1 <= 3'b110;
         req_wdata_p1 <= 64'd0;
      end else if (d_gnt_c) begin
         req_addr_p1  <= mp.d_addr;
         req_we_p1    <= mp.d_we;
         req_width_p1 <= mp.d_width;
         req_wdata_p1 <= mp.d_wdata;
      end
   end

   assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_D);
   assign busy_d = (state_q == BUSY_D);

   assign mp.bus_req   = busy;
   assign mp.bus_we    = busy_d && req_we_p1;
   assign mp.bus_addr  = busy ? {req_addr_p1[63:3], 3'b000} : 64'd0;
   assign mp.bus_wdata = busy_d ? (req_wdata_p1 << {req_addr_p1[2:0], 3'b000}) : 64'd0;
   assign mp.bus_wmask = busy_d ? lane_mask(req_addr_p1[2:0], req_width_p1[1:0]) : 8'd0;

   // Stage 2: results registered on ack, presented in DONE and held until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata_p2 <= 32'd0;
         d_rdata_p2  <= 64'd0;
      end else if (mp.bus_ack) begin
         if (state_q == BUSY_IF)
            if_rdata_p2 <= req_addr_p1[2] ? mp.bus_rdata[63:32] : mp.bus_rdata[31:0];
         if (state_q == BUSY_D)
            d_rdata_p2 <= req_we_p1 ? 64'd0
                                    : load_extend(mp.bus_rdata, req_addr_p1[2:0], req_width_p1);
      end
   end

   assign mp.if_gnt    = if_gnt_c;
   assign mp.if_fault  = if_fault_c;
   assign mp.d_gnt     = d_gnt_c;
   assign mp.d_fault   = d_fault_c;
   assign mp.if_rvalid = (state_q == DONE) && !sel_d_p1;
   assign mp.d_rvalid  = (state_q == DONE) && sel_d_p1;
   assign mp.if_rdata  = if_rdata_p2;
   assign mp.d_rdata   = d_rdata_p2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed lane/extension/fault vectors, hand-built corner sequences,
// and random single accesses checked against an arithmetic model of the lane rules.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mem_port_arbiter_if mp ();

   mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk (clk),
      .rst (rst),
      .mp  (mp.slave)
   );

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [2:0]  width;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        fault;
      logic [63:0] baddr;
      logic [7:0]  mask;
      logic [63:0] bwdata;
      logic [63:0] res;
   } vec_t;

   vec_t vecs[14];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference for one data access, from the size/offset arithmetic rules.
   function automatic vec_t model_data(input logic we, input logic [63:0] addr, input logic [2:0] width,
                                       input logic [63:0] wdata, input logic [63:0] rdata);
      vec_t        v;
      int          sz;
      int          off;
      logic [63:0] val;
      logic [63:0] span;
      sz  = 1 << width[1:0];
      off = int'(addr % 64'd8);
      v.we = we; v.addr = addr; v.width = width; v.wdata = wdata; v.rdata = rdata;
      v.fault  = (width == 3'b111) || (we && width >= 3'd4) || ((addr % 64'(sz)) != 64'd0);
      v.baddr  = addr - 64'(off);
      v.mask   = 8'(((1 << sz) - 1) << off);
      v.bwdata = wdata << (8 * off);
      if (we) v.res = 64'd0;
      else begin
         val = rdata >> (8 * off);
         if (sz < 8) begin
            span = 64'h1 << (8 * sz);
            val  = val % span;
            if (width < 3'd4 && val >= (span >> 1)) val = val - span;
         end
         v.res = val;
      end
      return v;
   endfunction

   task automatic data_access(input vec_t v, input int delay, input logic hold_if);
      @(posedge clk); #1;
      mp.d_req = 1'b1; mp.d_we = v.we; mp.d_addr = v.addr; mp.d_width = v.width;
      mp.d_wdata = v.wdata; mp.bus_ack = 1'b0;
      @(negedge clk);
      chk("d_fault", mp.d_fault, v.fault);
      chk("d_gnt", mp.d_gnt, !v.fault);
      @(posedge clk); #1;
      mp.d_req = 1'b0;
      if (v.fault) begin
         @(negedge clk);
         chk("d_fault_no_bus", mp.bus_req, 1'b0);
      end else begin
         mp.if_req = hold_if; mp.if_addr = 64'h9000;
         for (int w = 0; w <= delay; w++) begin
            mp.bus_ack   = (w == delay);
            mp.bus_rdata = (w == delay) ? v.rdata : ~v.rdata;
            @(negedge clk);
            chk("bus_req", mp.bus_req, 1'b1);
            chk("bus_we", mp.bus_we, v.we);
            chk("bus_addr", mp.bus_addr, v.baddr);
            chk("bus_wmask", mp.bus_wmask, v.mask);
            chk("bus_wdata", mp.bus_wdata, v.bwdata);
            chk("d_rvalid_early", mp.d_rvalid, 1'b0);
            chk("no_gnt_busy", {mp.if_gnt, mp.d_gnt}, 2'b00);
            @(posedge clk); #1;
         end
         mp.bus_ack = 1'b0; mp.bus_rdata = 64'd0; mp.if_req = 1'b0;
         @(negedge clk);
         chk("d_rvalid", mp.d_rvalid, 1'b1);
         chk("d_rdata", mp.d_rdata, v.res);
         chk("done_no_bus", mp.bus_req, 1'b0);
         chk("no_gnt_done", mp.if_gnt, 1'b0);
      end
   endtask

   task automatic fetch_access(input logic [63:0] addr, input logic [63:0] rdata, input int delay);
      logic        exp_fault;
      logic [31:0] exp_word;
      exp_fault = (addr % 64'd4) != 64'd0;
      exp_word  = ((addr % 64'd8) >= 64'd4) ? 32'(rdata / 64'h1_0000_0000) : 32'(rdata % 64'h1_0000_0000);
      @(posedge clk); #1;
      mp.if_req = 1'b1; mp.if_addr = addr; mp.bus_ack = 1'b0;
      @(negedge clk);
      chk("if_fault", mp.if_fault, exp_fault);
      chk("if_gnt", mp.if_gnt, !exp_fault);
      @(posedge clk); #1;
      mp.if_req = 1'b0;
      if (exp_fault) begin
         @(negedge clk);
         chk("if_fault_no_bus", mp.bus_req, 1'b0);
      end else begin
         for (int w = 0; w <= delay; w++) begin
            mp.bus_ack   = (w == delay);
            mp.bus_rdata = (w == delay) ? rdata : ~rdata;
            @(negedge clk);
            chk("if_bus_req", mp.bus_req, 1'b1);
            chk("if_bus_we", mp.bus_we, 1'b0);
            chk("if_bus_addr", mp.bus_addr, addr - (addr % 64'd8));
            chk("if_rvalid_early", mp.if_rvalid, 1'b0);
            @(posedge clk); #1;
         end
         mp.bus_ack = 1'b0; mp.bus_rdata = 64'd0;
         @(negedge clk);
         chk("if_rvalid", mp.if_rvalid, 1'b1);
         chk("if_rdata", mp.if_rdata, exp_word);
      end
   endtask

   initial begin
      vec_t  v;
      string seq;
      int    n;
      logic [63:0] a;
      checks = 0; failures = 0;
      mp.if_req = 0; mp.if_addr = 0; mp.d_req = 0; mp.d_we = 0; mp.d_addr = 0;
      mp.d_width = 0; mp.d_wdata = 0; mp.bus_ack = 0; mp.bus_rdata = 0;

      vecs[0]  = '{1'b0, 64'h1003, 3'b000, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 64'h1000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[1]  = '{1'b0, 64'h1003, 3'b100, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 64'h1000, 8'h08, 64'h0, 64'h80};
      vecs[2]  = '{1'b1, 64'h2006, 3'b001, 64'h1234, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h2000, 8'hC0, 64'h1234_0000_0000_0000, 64'h0};
      vecs[3]  = '{1'b0, 64'h1002, 3'b010, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0};
      vecs[4]  = '{1'b0, 64'h1000, 3'b111, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0};
      vecs[5]  = '{1'b1, 64'h1000, 3'b100, 64'h5, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0};
      vecs[6]  = '{1'b0, 64'h3008, 3'b011, 64'h0, 64'h8123_4567_89AB_CDEF, 1'b0, 64'h3008, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF};
      vecs[7]  = '{1'b0, 64'h3002, 3'b101, 64'h0, 64'h0000_0000_ABCD_0000, 1'b0, 64'h3000, 8'h0C, 64'h0, 64'hABCD};
      vecs[8]  = '{1'b0, 64'h3002, 3'b001, 64'h0, 64'h0000_0000_ABCD_0000, 1'b0, 64'h3000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD};
      vecs[9]  = '{1'b1, 64'h2004, 3'b010, 64'hCAFE_BABE, 64'h0, 1'b0, 64'h2000, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0};
      vecs[10] = '{1'b0, 64'h1004, 3'b110, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'h1000, 8'hF0, 64'h0, 64'h8765_4321};
      vecs[11] = '{1'b0, 64'h1004, 3'b010, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'h1000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321};
      vecs[12] = '{1'b1, 64'h2004, 3'b011, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0};
      vecs[13] = '{1'b1, 64'h2001, 3'b000, 64'hAB, 64'h0, 1'b0, 64'h2000, 8'h02, 64'hAB00, 64'h0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_bus_req", mp.bus_req, 1'b0);
      chk("rst_gnt", {mp.if_gnt, mp.d_gnt, mp.if_rvalid, mp.d_rvalid}, 4'b0);
      chk("rst_d_rdata", mp.d_rdata, 64'd0);
      chk("rst_if_rdata", mp.if_rdata, 64'd0);

      for (int i = 0; i < 14; i++) data_access(vecs[i], i % 3, 1'(i % 2));

      fetch_access(64'h4002, 64'h0, 0);
      fetch_access(64'h8004, 64'hAAAA_BBBB_CCCC_DDDD, 1);
      fetch_access(64'h8000, 64'hAAAA_BBBB_CCCC_DDDD, 0);

      // both ports fault in the same cycle
      @(posedge clk); #1;
      mp.if_req = 1; mp.if_addr = 64'h4002; mp.d_req = 1; mp.d_we = 0; mp.d_addr = 64'h1000; mp.d_width = 3'b111;
      @(negedge clk);
      chk("dual_fault", {mp.if_fault, mp.d_fault, mp.if_gnt, mp.d_gnt}, 4'b1100);
      @(posedge clk); #1;
      mp.if_req = 0; mp.d_req = 0;
      @(negedge clk);
      chk("dual_fault_no_bus", mp.bus_req, 1'b0);

      // long wait states with a competing fetch held during the access
      data_access(vecs[6], 5, 1'b1);

      // starvation limit with both ports requesting continuously
      v = model_data(1'b0, 64'h1000, 3'b010, 64'h0, 64'h1122_3344_5566_7788);
      @(posedge clk); #1;
      mp.if_req = 1; mp.if_addr = 64'h8004; mp.d_req = 1; mp.d_we = 0; mp.d_addr = 64'h1000;
      mp.d_width = 3'b010; mp.bus_ack = 1; mp.bus_rdata = 64'h1122_3344_5566_7788;
      seq = ""; n = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         @(negedge clk);
         if (mp.if_gnt) begin seq = {seq, "I"}; n++; end
         if (mp.d_gnt)  begin seq = {seq, "D"}; n++; end
         if (mp.if_rvalid) chk("starve_if_rdata", mp.if_rdata, 64'h1122_3344);
         if (mp.d_rvalid)  chk("starve_d_rdata", mp.d_rdata, v.res);
      end
      checks++;
      if (seq != "DDDDIDDDDI") begin
         failures++;
         $display("FAIL grant_order actual=%s required=DDDDIDDDDI", seq);
      end
      @(posedge clk); #1;
      mp.if_req = 0; mp.d_req = 0;
      repeat (3) @(posedge clk);
      #1 mp.bus_ack = 0;

      // reset in the middle of a data access, with ack in the same cycle
      @(posedge clk); #1;
      mp.d_req = 1; mp.d_we = 0; mp.d_addr = 64'h1000; mp.d_width = 3'b011;
      @(negedge clk);
      chk("rstmid_gnt", mp.d_gnt, 1'b1);
      @(posedge clk); #1;
      mp.d_req = 0;
      @(negedge clk);
      chk("rstmid_busy", mp.bus_req, 1'b1);
      @(posedge clk); #1;
      rst = 1; mp.bus_ack = 1; mp.bus_rdata = 64'hFEDC_BA98_7654_3210;
      @(posedge clk); #1;
      rst = 0; mp.bus_ack = 0;
      @(negedge clk);
      chk("rstmid_bus", {mp.bus_req, mp.bus_we, mp.bus_wmask}, 10'd0);
      chk("rstmid_bus_addr", mp.bus_addr, 64'd0);
      chk("rstmid_bus_wdata", mp.bus_wdata, 64'd0);
      chk("rstmid_flags", {mp.d_rvalid, mp.if_rvalid, mp.d_gnt, mp.if_gnt, mp.d_fault, mp.if_fault}, 6'd0);
      chk("rstmid_d_rdata", mp.d_rdata, 64'd0);
      chk("rstmid_if_rdata", mp.if_rdata, 64'd0);
      @(negedge clk);
      chk("rstmid_no_rvalid", mp.d_rvalid, 1'b0);
      fetch_access(64'h5000, 64'h0BAD_F00D_600D_CAFE, 0);

      // random single accesses on either port
      for (int i = 0; i < 120; i++) begin
         a = 64'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            fetch_access(a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
         end else begin
            logic [2:0]  wd;
            logic [63:0] wdat;
            wd   = 3'($urandom_range(0, 7));
            wdat = {$urandom, $urandom};
            if (wd[1:0] != 2'd3) wdat = wdat % (64'h1 << (8 * (1 << wd[1:0])));
            v = model_data(1'($urandom_range(0, 1)), a, wd, wdat, {$urandom, $urandom});
            data_access(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
